// File: rtl/regfile_bypass_init_if.sv
// Register-file access bundle: one write port with byte enables, two read
// ports, init request and busy flag.
//   master: drives init/write/read-address signals, receives read data + busy
//   slave : the register file side
interface regfile_bypass_init_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic                  i_init;
  logic                  i_WriteEn;
  logic [ADDR_W-1:0]     i_WriteAddress;
  logic [DATA_W-1:0]     i_WriteData;
  logic [DATA_W/8-1:0]   i_WriteByteEn;
  logic [ADDR_W-1:0]     i_ReadAddress;
  logic [ADDR_W-1:0]     i_ReadAddress2;
  logic [DATA_W-1:0]     o_ReadData;
  logic [DATA_W-1:0]     o_ReadData2;
  logic                  o_busy;

  modport master (
    output i_init, i_WriteEn, i_WriteAddress, i_WriteData, i_WriteByteEn,
           i_ReadAddress, i_ReadAddress2,
    input  o_ReadData, o_ReadData2, o_busy
  );

  modport slave (
    input  i_init, i_WriteEn, i_WriteAddress, i_WriteData, i_WriteByteEn,
           i_ReadAddress, i_ReadAddress2,
    output o_ReadData, o_ReadData2, o_busy
  );
endinterface

// File: rtl/regfile_bypass_init.sv
// Multi-ported register file: two combinational read ports, one synchronous
// byte-enabled write port, optional hardwired-zero entry 0, optional
// write-to-read bypass, and a clocked init sequencer loading entry k with k.
// Ports:
//   i_clk   : clock, rising edge
//   i_rst_n : asynchronous active-low reset (clears array, FSM to IDLE)
//   bus     : regfile_bypass_init_if.slave (init/write/read signals, busy)
//
// state   | meaning
// --------+---------------------------------------------------------------
// ST_IDLE | normal operation, user writes accepted, bypass active
// ST_INIT | writing entry cnt_q = cnt_q each cycle, user writes dropped
module regfile_bypass_init #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  regfile_bypass_init_if.slave  bus
);
  localparam int DEPTH = 2**ADDR_W;
  localparam int NB    = DATA_W/8;

  typedef enum logic {ST_IDLE, ST_INIT} state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] cnt_q;
  logic              busy_q;
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [DATA_W-1:0] merged_d;
  logic              user_wr;
  logic [DATA_W-1:0] rd1_d;
  logic [DATA_W-1:0] rd2_d;

  // New value of the addressed entry after byte-merging the write data.
  always_comb begin
    merged_d = mem_q[bus.i_WriteAddress];
    for (int b = 0; b < NB; b++) begin
      if (bus.i_WriteByteEn[b]) merged_d[8*b +: 8] = bus.i_WriteData[8*b +: 8];
    end
  end

  // Writes to entry 0 are discarded entirely when it is hardwired to zero,
  // which also keeps them out of the bypass path.
  assign user_wr = (state_q == ST_IDLE) && bus.i_WriteEn &&
                   !((ZERO_REG != 0) && (bus.i_WriteAddress == '0));

  always_comb begin
    rd1_d = mem_q[bus.i_ReadAddress];
    if ((BYPASS != 0) && user_wr && (bus.i_ReadAddress == bus.i_WriteAddress))
      rd1_d = merged_d;
    if ((ZERO_REG != 0) && (bus.i_ReadAddress == '0))
      rd1_d = '0;
  end

  always_comb begin
    rd2_d = mem_q[bus.i_ReadAddress2];
    if ((BYPASS != 0) && user_wr && (bus.i_ReadAddress2 == bus.i_WriteAddress))
      rd2_d = merged_d;
    if ((ZERO_REG != 0) && (bus.i_ReadAddress2 == '0))
      rd2_d = '0;
  end

  assign bus.o_ReadData  = rd1_d;
  assign bus.o_ReadData2 = rd2_d;
  assign bus.o_busy      = busy_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (user_wr) mem_q[bus.i_WriteAddress] <= merged_d;
          if (bus.i_init) begin
            state_q <= ST_INIT;
            busy_q  <= 1'b1;
            cnt_q   <= '0;
          end
        end
        ST_INIT: begin
          if (!((ZERO_REG != 0) && (cnt_q == '0)))
            mem_q[cnt_q] <= DATA_W'(cnt_q);
          // cnt_q wraps to 0 on the last entry, ready for the next run.
          cnt_q <= cnt_q + ADDR_W'(1);
          if (&cnt_q) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_regfile_bypass_init.sv
// Bench for regfile_bypass_init: two instances (BYPASS=1 and BYPASS=0, both
// ZERO_REG=1) share one stimulus stream; expected read data per instance
// travels through a queue from the drive point to the sample point.
module tb_regfile_bypass_init;
  logic i_clk;
  logic i_rst_n;

  regfile_bypass_init_if #(.DATA_W(32), .ADDR_W(5)) b_if ();
  regfile_bypass_init_if #(.DATA_W(32), .ADDR_W(5)) n_if ();

  regfile_bypass_init #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(1)) u_byp (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .bus(b_if.slave));
  regfile_bypass_init #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(0)) u_nb (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .bus(n_if.slave));

  assign n_if.i_init         = b_if.i_init;
  assign n_if.i_WriteEn      = b_if.i_WriteEn;
  assign n_if.i_WriteAddress = b_if.i_WriteAddress;
  assign n_if.i_WriteData    = b_if.i_WriteData;
  assign n_if.i_WriteByteEn  = b_if.i_WriteByteEn;
  assign n_if.i_ReadAddress  = b_if.i_ReadAddress;
  assign n_if.i_ReadAddress2 = b_if.i_ReadAddress2;

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  typedef struct {
    logic        init;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [3:0]  be;
    logic [4:0]  ra;
    logic [4:0]  ra2;
    logic [31:0] e1;   // bypass instance, port 1
    logic [31:0] e2;   // bypass instance, port 2
    logic [31:0] n1;   // no-bypass instance, port 1
    logic [31:0] n2;   // no-bypass instance, port 2
    logic        eb;   // busy
  } vec_t;

  vec_t sb_q[$];
  vec_t tbl[10];
  int   n_checks = 0;
  int   n_err    = 0;

  function automatic vec_t mkv(input logic init, input logic we, input logic [4:0] wa,
                               input logic [31:0] wd, input logic [3:0] be,
                               input logic [4:0] ra, input logic [4:0] ra2,
                               input logic [31:0] e1, input logic [31:0] e2,
                               input logic [31:0] n1, input logic [31:0] n2,
                               input logic eb);
    vec_t v;
    v.init = init; v.we = we; v.wa = wa; v.wd = wd; v.be = be;
    v.ra = ra; v.ra2 = ra2; v.e1 = e1; v.e2 = e2; v.n1 = n1; v.n2 = n2; v.eb = eb;
    return v;
  endfunction

  task automatic check32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual 0x%08h required 0x%08h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    b_if.i_init         = v.init;
    b_if.i_WriteEn      = v.we;
    b_if.i_WriteAddress = v.wa;
    b_if.i_WriteData    = v.wd;
    b_if.i_WriteByteEn  = v.be;
    b_if.i_ReadAddress  = v.ra;
    b_if.i_ReadAddress2 = v.ra2;
  endtask

  task automatic drive_idle(input logic [4:0] ra, input logic [4:0] ra2);
    drive(mkv(1'b0, 1'b0, 5'd0, 32'h0, 4'h0, ra, ra2, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0));
  endtask

  // Called just after a rising edge; returns just after the next one.
  task automatic run_vec(input vec_t v, input string nm);
    vec_t e;
    drive(v);
    sb_q.push_back(v);
    @(negedge i_clk);
    e = sb_q.pop_front();
    check32({nm, ".byp_rd1"}, b_if.o_ReadData,  e.e1);
    check32({nm, ".byp_rd2"}, b_if.o_ReadData2, e.e2);
    check32({nm, ".nb_rd1"},  n_if.o_ReadData,  e.n1);
    check32({nm, ".nb_rd2"},  n_if.o_ReadData2, e.n2);
    check32({nm, ".busy"},    {31'b0, b_if.o_busy}, {31'b0, e.eb});
    check32({nm, ".nb_busy"}, {31'b0, n_if.o_busy}, {31'b0, e.eb});
    @(posedge i_clk); #1;
  endtask

  // Called just after the edge that samples the init pulse. Counts busy
  // cycles (bounded); optionally attempts a user write during the first one.
  task automatic count_busy(output int n, input bit write_during);
    n = 0;
    for (int i = 0; i < 100; i++) begin
      if (i == 0 && write_during)
        drive(mkv(1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 4'hF, 5'd5, 5'd5,
                  32'h0, 32'h0, 32'h0, 32'h0, 1'b1));
      else
        drive_idle(5'd0, 5'd0);
      @(negedge i_clk);
      if (i == 0) begin
        check32("busy_start", {31'b0, b_if.o_busy}, 32'd1);
        if (write_during) begin
          check32("busy_nofwd_rd1", b_if.o_ReadData,  32'h0);
          check32("busy_nofwd_rd2", b_if.o_ReadData2, 32'h0);
        end
      end
      if (b_if.o_busy) n++;
      else break;
    end
    @(posedge i_clk); #1;
  endtask

  int nb;

  initial begin
    i_rst_n = 1'b1;
    drive_idle(5'd0, 5'd0);

    tbl[0] = mkv(0, 1, 5'd3,  32'hAABBCCDD, 4'b1010, 5'd3,  5'd3,
                 32'hAA00CC03, 32'hAA00CC03, 32'h00000003, 32'h00000003, 0);
    tbl[1] = mkv(0, 0, 5'd0,  32'h0,        4'b0000, 5'd3,  5'd7,
                 32'hAA00CC03, 32'h00000007, 32'hAA00CC03, 32'h00000007, 0);
    tbl[2] = mkv(0, 1, 5'd9,  32'h12345678, 4'b1111, 5'd9,  5'd10,
                 32'h12345678, 32'h0000000A, 32'h00000009, 32'h0000000A, 0);
    tbl[3] = mkv(0, 0, 5'd0,  32'h0,        4'b0000, 5'd9,  5'd10,
                 32'h12345678, 32'h0000000A, 32'h12345678, 32'h0000000A, 0);
    tbl[4] = mkv(0, 1, 5'd0,  32'hFFFFFFFF, 4'b1111, 5'd0,  5'd0,
                 32'h0, 32'h0, 32'h0, 32'h0, 0);
    tbl[5] = mkv(0, 0, 5'd0,  32'h0,        4'b0000, 5'd0,  5'd0,
                 32'h0, 32'h0, 32'h0, 32'h0, 0);
    tbl[6] = mkv(0, 1, 5'd12, 32'h11223344, 4'b0000, 5'd12, 5'd12,
                 32'h0000000C, 32'h0000000C, 32'h0000000C, 32'h0000000C, 0);
    tbl[7] = mkv(0, 0, 5'd0,  32'h0,        4'b0000, 5'd12, 5'd0,
                 32'h0000000C, 32'h0, 32'h0000000C, 32'h0, 0);
    tbl[8] = mkv(0, 1, 5'd20, 32'hCAFEF00D, 4'b0001, 5'd20, 5'd21,
                 32'h0000000D, 32'h00000015, 32'h00000014, 32'h00000015, 0);
    tbl[9] = mkv(0, 0, 5'd0,  32'h0,        4'b0000, 5'd20, 5'd31,
                 32'h0000000D, 32'h0000001F, 32'h0000000D, 32'h0000001F, 0);

    // Reset asserted and released between clock edges.
    #7  i_rst_n = 1'b0;
    #20 i_rst_n = 1'b1;
    @(posedge i_clk); #1;
    for (int i = 0; i < 32; i++)
      run_vec(mkv(0, 0, 5'd0, 32'h0, 4'h0, 5'(i), 5'(31 - i),
                  32'h0, 32'h0, 32'h0, 32'h0, 0), "reset_read");

    // Init sequence with a dropped write during busy.
    run_vec(mkv(1, 0, 5'd0, 32'h0, 4'h0, 5'd0, 5'd0,
                32'h0, 32'h0, 32'h0, 32'h0, 0), "init_pulse");
    count_busy(nb, 1'b1);
    check32("busy_len", 32'(nb), 32'd32);
    run_vec(mkv(0, 0, 5'd0, 32'h0, 4'h0, 5'd7, 5'd31,
                32'h7, 32'h1F, 32'h7, 32'h1F, 0), "after_init_7_31");
    run_vec(mkv(0, 0, 5'd0, 32'h0, 4'h0, 5'd0, 5'd5,
                32'h0, 32'h5, 32'h0, 32'h5, 0), "after_init_0_5");

    // Byte enables, bypass, zero register, no-op writes.
    for (int i = 0; i < 10; i++) run_vec(tbl[i], $sformatf("tbl%0d", i));

    // i_init ignored while busy: a second pulse mid-sequence must not extend it.
    run_vec(mkv(1, 0, 5'd0, 32'h0, 4'h0, 5'd0, 5'd0,
                32'h0, 32'h0, 32'h0, 32'h0, 0), "init_pulse2");
    for (int i = 0; i < 3; i++) begin
      drive_idle(5'd0, 5'd0);
      @(posedge i_clk); #1;
    end
    b_if.i_init = 1'b1;
    @(posedge i_clk); #1;
    nb = 4;
    for (int i = 0; i < 100; i++) begin
      drive_idle(5'd0, 5'd0);
      @(negedge i_clk);
      if (b_if.o_busy) nb++;
      else break;
      @(posedge i_clk); #1;
    end
    @(posedge i_clk); #1;
    check32("busy_len_no_restart", 32'(nb), 32'd32);

    // Reset in the middle of an init sequence.
    run_vec(mkv(1, 0, 5'd0, 32'h0, 4'h0, 5'd0, 5'd0,
                32'h0, 32'h0, 32'h0, 32'h0, 0), "init_pulse3");
    for (int i = 0; i < 10; i++) begin
      drive_idle(5'd4, 5'd4);
      @(posedge i_clk); #1;
    end
    #2;
    check32("pre_reset_a4", b_if.o_ReadData, 32'h4);
    i_rst_n = 1'b0;
    #1;
    check32("midreset_busy",    {31'b0, b_if.o_busy}, 32'd0);
    check32("midreset_nb_busy", {31'b0, n_if.o_busy}, 32'd0);
    check32("midreset_a4",      b_if.o_ReadData, 32'h0);
    check32("midreset_nb_a4",   n_if.o_ReadData, 32'h0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    @(posedge i_clk); #1;
    run_vec(mkv(0, 0, 5'd0, 32'h0, 4'h0, 5'd4, 5'd31,
                32'h0, 32'h0, 32'h0, 32'h0, 0), "after_reset_idle");
    run_vec(mkv(1, 0, 5'd0, 32'h0, 4'h0, 5'd0, 5'd0,
                32'h0, 32'h0, 32'h0, 32'h0, 0), "init_pulse4");
    count_busy(nb, 1'b0);
    check32("busy_len_restart", 32'(nb), 32'd32);
    run_vec(mkv(0, 0, 5'd0, 32'h0, 4'h0, 5'd4, 5'd31,
                32'h4, 32'h1F, 32'h4, 32'h1F, 0), "after_restart");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: actual running required finished");
    $fatal(1);
  end
endmodule
